// File: rtl/duty_ramp.sv
// Duty ramp feeder for the PWM stage: slews duty toward a handshaked target in bounded steps,
// with period-aligned load strobes. Define DUTY_RAMP_GAMMA_EN for a square-law duty_out map.
module duty_ramp #(
    parameter int unsigned N_BIT  = 10,
    parameter int unsigned STEP_W = 4,
    parameter int unsigned RATE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_BIT-1:0]  target,
    input  logic              target_valid,
    output logic              target_ready,
    input  logic [STEP_W-1:0] step,
    input  logic [RATE_W-1:0] rate,
    output logic [N_BIT-1:0]  duty_out,
    output logic              load,
    output logic              busy,
    output logic              done
);

    localparam int unsigned EXT_W  = N_BIT + 1;
    localparam int unsigned RCNT_W = RATE_W + 1;
`ifdef DUTY_RAMP_GAMMA_EN
    localparam int unsigned SQ_W   = 2 * N_BIT;
`endif

    typedef enum logic [0:0] {IDLE, RAMP} state_t;

    state_t             state_q, state_d;
    logic [N_BIT-1:0]   pcnt_q;
    logic [RATE_W-1:0]  rcnt_q, rcnt_d;
    logic               init_pending_q, init_pending_d;
    logic [N_BIT-1:0]   tgt_q, tgt_d;
    logic [N_BIT-1:0]   lin_q, lin_d;
    logic [N_BIT-1:0]   duty_d;
    logic               load_d, busy_d, done_d, ready_d;

    logic               period_end;
    logic               step_tick;
    logic [STEP_W-1:0]  s_eff;
    logic [RATE_W-1:0]  r_eff;
    logic [EXT_W-1:0]   up_sum, dn_diff;
    logic [N_BIT-1:0]   nxt;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            pcnt_q         <= '0;
            rcnt_q         <= '0;
            init_pending_q <= 1'b1;
            tgt_q          <= '0;
            lin_q          <= '0;
            duty_out       <= '0;
            load           <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            target_ready   <= 1'b0;
        end else begin
            state_q        <= state_d;
            pcnt_q         <= pcnt_q + N_BIT'(1);
            rcnt_q         <= rcnt_d;
            init_pending_q <= init_pending_d;
            tgt_q          <= tgt_d;
            lin_q          <= lin_d;
            duty_out       <= duty_d;
            load           <= load_d;
            busy           <= busy_d;
            done           <= done_d;
            target_ready   <= ready_d;
        end
    end

    // Next-state, rate divider and clamped step arithmetic
    always_comb begin
        state_d        = state_q;
        rcnt_d         = rcnt_q;
        init_pending_d = init_pending_q;
        tgt_d          = tgt_q;
        lin_d          = lin_q;
        load_d         = 1'b0;
        done_d         = 1'b0;
        busy_d         = busy;
        ready_d        = target_ready;
        step_tick      = 1'b0;

        period_end = (pcnt_q == '1);
        s_eff      = (step == '0) ? STEP_W'(1) : step;
        r_eff      = (rate == '0) ? RATE_W'(1) : rate;
        up_sum     = EXT_W'(lin_q) + EXT_W'(s_eff);
        dn_diff    = EXT_W'(lin_q) - EXT_W'(s_eff);

        if (tgt_q > lin_q) begin
            nxt = (up_sum >= EXT_W'(tgt_q)) ? tgt_q : up_sum[N_BIT-1:0];
        end else begin
            // Borrow out of the extended subtraction means we went below zero
            nxt = (dn_diff[N_BIT] || (dn_diff[N_BIT-1:0] <= tgt_q)) ? tgt_q : dn_diff[N_BIT-1:0];
        end

        if (period_end && init_pending_q) begin
            load_d         = 1'b1;
            init_pending_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (target_valid && target_ready) begin
                    tgt_d = target;
                    if (target != lin_q) begin
                        state_d = RAMP;
                        ready_d = 1'b0;
                        busy_d  = 1'b1;
                        rcnt_d  = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RAMP: begin
                ready_d = 1'b0;
                if (period_end && !init_pending_q) begin
                    if ((RCNT_W'(rcnt_q) + RCNT_W'(1)) >= RCNT_W'(r_eff)) begin
                        step_tick = 1'b1;
                        rcnt_d    = '0;
                    end else begin
                        rcnt_d = rcnt_q + RATE_W'(1);
                    end
                end
                if (step_tick) begin
                    lin_d  = nxt;
                    load_d = 1'b1;
                    if (nxt == tgt_q) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                        ready_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output duty map, registered alongside load
    always_comb begin
`ifdef DUTY_RAMP_GAMMA_EN
        duty_d = N_BIT'((SQ_W'(lin_d) * SQ_W'(lin_d)) >> N_BIT);
`else
        duty_d = lin_d;
`endif
    end

endmodule

// File: tb/tb_duty_ramp.sv
// Self-checking bench for duty_ramp at N_BIT=4: scoreboard of expected load/done events
// plus a table of ramp targets and hand-written reset and ignored-target sequences.
module tb_duty_ramp;

    localparam int unsigned N_BIT  = 4;
    localparam int unsigned STEP_W = 4;
    localparam int unsigned RATE_W = 8;
    localparam int          PER    = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N_BIT-1:0]  target;
    logic              target_valid;
    logic              target_ready;
    logic [STEP_W-1:0] step;
    logic [RATE_W-1:0] rate;
    logic [N_BIT-1:0]  duty_out;
    logic              load;
    logic              busy;
    logic              done;

    duty_ramp #(.N_BIT(N_BIT), .STEP_W(STEP_W), .RATE_W(RATE_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .target(target), .target_valid(target_valid), .target_ready(target_ready),
        .step(step), .rate(rate),
        .duty_out(duty_out), .load(load), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N_BIT-1:0] lin;
        logic             ld;
        logic             dn;
        int               gap;   // expected clocks since previous load, 0 = unchecked
        int               bz;    // expected busy, -1 = unchecked
    } exp_t;

    typedef struct {
        logic [N_BIT-1:0]  t;
        logic [STEP_W-1:0] s;
        logic [RATE_W-1:0] r;
    } vec_t;

    exp_t             q[$];
    exp_t             e;
    int               n_tests = 0;
    int               n_fail  = 0;
    int               cyc     = 0;
    int               last_load = 0;
    logic [N_BIT-1:0] last_lin = '0;
    logic [N_BIT-1:0] m_duty = '0;
    vec_t             vecs[5];

    function automatic logic [N_BIT-1:0] map_duty(input logic [N_BIT-1:0] l);
`ifdef DUTY_RAMP_GAMMA_EN
        return N_BIT'((32'(l) * 32'(l)) >> N_BIT);
`else
        return l;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every load or done pulse must match the next expected event
    always @(negedge clk) begin
        cyc++;
        if (rst_n && (load || done)) begin
            if (q.size() == 0) begin
                check("unexpected_event", {30'd0, load, done}, 0);
            end else begin
                e = q.pop_front();
                check("load", load, e.ld);
                check("done", done, e.dn);
                if (e.bz >= 0) check("busy", busy, e.bz);
                if (e.ld) check("duty_out", duty_out, map_duty(e.lin));
                if (e.gap != 0) check("load_gap", cyc - last_load, e.gap);
                if (load) last_load = cyc;
                last_lin = e.lin;
            end
        end
    end

    // Reference ramp: push the expected event sequence for one accepted target
    task automatic plan(input logic [N_BIT-1:0] t, input int s, input int r);
        int se = (s == 0) ? 1 : s;
        int re = (r == 0) ? 1 : r;
        int d  = int'(m_duty);
        int ti = int'(t);
        bit first = 1'b1;
        if (ti == d) begin
            q.push_back('{lin: t, ld: 1'b0, dn: 1'b1, gap: 0, bz: 0});
        end else begin
            while (d != ti) begin
                if (ti > d) d = (d + se >= ti) ? ti : d + se;
                else        d = (d - se <= ti) ? ti : d - se;
                q.push_back('{lin: N_BIT'(d), ld: 1'b1, dn: (d == ti), gap: first ? 0 : PER * re,
                              bz: (d == ti) ? 0 : 1});
                first = 1'b0;
            end
        end
        m_duty = t;
    endtask

    task automatic send(input logic [N_BIT-1:0] t, input logic [STEP_W-1:0] s,
                        input logic [RATE_W-1:0] r);
        int n = 0;
        bit eq = (t == m_duty);
        @(negedge clk); #1;
        while (!target_ready && n < 2000) begin
            @(negedge clk); #1;
            n++;
        end
        if (!target_ready) begin
            check("ready_timeout", target_ready, 1);
            return;
        end
        plan(t, int'(s), int'(r));
        target = t; step = s; rate = r; target_valid = 1'b1;
        @(posedge clk); #1;
        target_valid = 1'b0;
        check("busy_after_hs", busy, !eq);
        check("ready_after_hs", target_ready, eq);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        check("idle_timeout", (q.size() == 0) && !busy, 1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; target = '0; target_valid = 1'b0; step = '0; rate = '0;
        vecs[0] = '{t: 4'd5,  s: 4'd1, r: 8'd1};
        vecs[1] = '{t: 4'd5,  s: 4'd2, r: 8'd1};
        vecs[2] = '{t: 4'd12, s: 4'd0, r: 8'd0};
        vecs[3] = '{t: 4'd3,  s: 4'd7, r: 8'd3};
        vecs[4] = '{t: 4'd14, s: 4'd5, r: 8'd2};

        #1;
        check("rst_duty", duty_out, 0);
        check("rst_load", load, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", target_ready, 0);
        q.push_back('{lin: '0, ld: 1'b1, dn: 1'b0, gap: 0, bz: -1});
        #21 rst_n = 1'b1;

        // Ramp up in steps of 3, accepted before the init load
        send(4'd10, 4'd3, 8'd1);   wait_idle();
        send(4'd2,  4'd4, 8'd2);   wait_idle();
        // Full-scale single steps in both directions, no wrap
        send(4'd0,  4'd15, 8'd1);  wait_idle();
        send(4'd15, 4'd15, 8'd1);  wait_idle();
        send(4'd0,  4'd15, 8'd1);  wait_idle();

        for (int i = 0; i < 5; i++) begin
            send(vecs[i].t, vecs[i].s, vecs[i].r);
            wait_idle();
            check("final_lin", last_lin, vecs[i].t);
            check("final_duty", duty_out, map_duty(vecs[i].t));
        end

        // Targets offered mid-ramp are ignored, with normal and zero step/rate
        for (int k = 0; k < 2; k++) begin
            logic [N_BIT-1:0] t;
            t = (k == 0) ? 4'd9 : 4'd12;
            if (k == 0) send(t, 4'd2, 8'd1);
            else        send(t, 4'd0, 8'd0);
            target = 4'd1; target_valid = 1'b1;
            repeat (10) begin
                @(negedge clk); #1;
                check("ready_in_ramp", target_ready, 0);
            end
            target_valid = 1'b0;
            wait_idle();
            check("ignored_final", last_lin, t);
        end

        // Asynchronous reset in the middle of a ramp, at duty 6
        send(4'd0, 4'd15, 8'd1);   wait_idle();
        send(4'd15, 4'd3, 8'd1);
        n = 0;
        while (last_lin != 4'd6 && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        check("reach_6", last_lin, 6);
        rst_n = 1'b0;
        #1;
        check("arst_duty", duty_out, 0);
        check("arst_busy", busy, 0);
        check("arst_load", load, 0);
        check("arst_ready", target_ready, 0);
        q.delete();
        m_duty = '0;
        repeat (2) @(negedge clk);
        q.push_back('{lin: '0, ld: 1'b1, dn: 1'b0, gap: 0, bz: 0});
        rst_n = 1'b1;
        #1;
        check("ready_pre_edge", target_ready, 0);
        @(posedge clk); #1;
        check("ready_post_edge", target_ready, 1);
        wait_idle();
        check("post_rst_lin", last_lin, 0);
        check("post_rst_duty", duty_out, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

endmodule
